oam_dma: RTL

OAM_DMA -- requirements
Module: oam_dma

---
 rtl/oam_dma.sv | 130 +++++++++++++
 1 files changed

// File: rtl/oam_dma.sv
// -----------------------------------------------------------------------------
// oam_dma -- sprite (OAM) DMA engine, CLK_NES domain.
//
// A CPU write to REG_ADDR latches a source page and halts the CPU while
// 256 bytes are copied from {PAGE, 8'h00..8'hFF} to OAM_DATA_ADDR, one
// read/write pair per byte. One dummy HALT cycle is always spent, plus an
// ALIGN cycle when HALT falls on an odd cycle.
//
// Ports
//   CLK         system clock, rising edge
//   RESET       synchronous, active-high
//   ADDR        CPU bus address (low 16 bits)
//   CPU_WR_N    CPU strobe, 1 = read, 0 = write
//   CPU_DO      CPU write data (source page on trigger)
//   DMA_DI      bus read data returned to DMA (1-cycle latency)
//   RDY         CPU ready, 0 halts the CPU
//   DMA_ACTIVE  1 while the DMA owns the bus
//   DMA_ADDR    DMA bus address
//   DMA_DO      DMA write data
//   DMA_WR_N    DMA strobe, 1 = read, 0 = write
//   DONE        one-cycle pulse after the last write
// -----------------------------------------------------------------------------
module oam_dma #(
  parameter logic [15:0] REG_ADDR      = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [15:0] ADDR,
  input  logic        CPU_WR_N,
  input  logic [7:0]  CPU_DO,
  input  logic [7:0]  DMA_DI,
  output logic        RDY,
  output logic        DMA_ACTIVE,
  output logic [15:0] DMA_ADDR,
  output logic [7:0]  DMA_DO,
  output logic        DMA_WR_N,
  output logic        DONE
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT,
    S_ALIGN,
    S_READ,
    S_WRITE
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] page;
  logic [7:0] idx;
  logic       parity;
  logic       done_q;
  logic       trigger;
  logic       last_write;

  // State and datapath registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state  <= S_IDLE;
      page   <= '0;
      idx    <= '0;
      parity <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      parity <= ~parity;
      // DONE is registered so it appears in the IDLE cycle after the last write
      done_q <= last_write;
      if (trigger) begin
        page <= CPU_DO;
        idx  <= '0;
      end else if (state == S_WRITE) begin
        idx  <= idx + 8'd1;
      end
    end
  end

  // Next-state and output decode; outputs depend on registered state only
  // (plus DMA_DI passed through as write data), never on ADDR/CPU_WR_N.
  always_comb begin
    state_nxt  = state;
    trigger    = 1'b0;
    last_write = 1'b0;
    RDY        = 1'b0;
    DMA_ACTIVE = 1'b1;
    DMA_ADDR   = '0;
    DMA_DO     = '0;
    DMA_WR_N   = 1'b1;

    case (state)
      S_IDLE: begin
        RDY        = 1'b1;
        DMA_ACTIVE = 1'b0;
        if ((ADDR == REG_ADDR) && !CPU_WR_N) begin
          trigger   = 1'b1;
          state_nxt = S_HALT;
        end
      end
      S_HALT: begin
        state_nxt = parity ? S_ALIGN : S_READ;
      end
      S_ALIGN: begin
        state_nxt = S_READ;
      end
      S_READ: begin
        DMA_ADDR  = {page, idx};
        state_nxt = S_WRITE;
      end
      S_WRITE: begin
        DMA_ADDR = OAM_DATA_ADDR;
        DMA_DO   = DMA_DI;
        DMA_WR_N = 1'b0;
        if (idx == 8'hFF) begin
          last_write = 1'b1;
          state_nxt  = S_IDLE;
        end else begin
          state_nxt  = S_READ;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign DONE = done_q;

endmodule
